// File: rtl/rob_commit_unit.sv
// Reorder-buffer commit end: in-order allocation, CDB completion tracking and
// in-order retirement, with branch-snapshot restore on a mispredicted commit.
module rob_commit_unit #(
  parameter int ROB   = 2,
  parameter int REG   = 4,
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             allocValid,
  input  logic             allocRegWrite,
  input  logic [REG:0]     allocDestReg,
  input  logic             allocIsBranch,
  input  logic [WIDTH:0]   allocSnap,
  output logic             allocReady,
  output logic [ROB:0]     destROB,
  input  logic             cdbValid,
  input  logic [ROB:0]     cdbROB,
  input  logic             cdbMispredict,
  output logic             validCommit,
  output logic [ROB:0]     commitROB,
  output logic [REG:0]     regCommit,
  output logic             flush,
  output logic [WIDTH:0]   statusRestore,
  output logic [ROB+1:0]   robCount
);

  localparam int DEPTH = 2 ** (ROB + 1);
  localparam logic [ROB+1:0] PTR_ONE = {{(ROB+1){1'b0}}, 1'b1};

  logic [ROB+1:0]   head_r, tail_r;
  logic [DEPTH-1:0] valid_r, done_r, misp_r, regwrite_r;
  logic [REG:0]     dest_r [DEPTH];
  logic [WIDTH:0]   snap_r [DEPTH];

  logic [ROB:0]     head_idx_s, tail_idx_s;
  logic [ROB+1:0]   head_next_s;
  logic             full_s, alloc_fire_s;

  assign head_idx_s   = head_r[ROB:0];
  assign tail_idx_s   = tail_r[ROB:0];
  assign head_next_s  = head_r + PTR_ONE;
  // Same slot with opposite wrap bits means every entry is occupied.
  assign full_s       = (head_idx_s == tail_idx_s) && (head_r[ROB+1] != tail_r[ROB+1]);
  assign allocReady   = ~full_s & ~flush;
  assign alloc_fire_s = allocValid & allocReady;
  assign destROB      = tail_idx_s;
  assign commitROB    = head_idx_s;
  assign robCount     = tail_r - head_r;

  // Retirement outputs, decoded from the registered head entry.
  always_comb begin
    validCommit = valid_r[head_idx_s] & done_r[head_idx_s] & ~reset;
    flush       = validCommit & misp_r[head_idx_s];
    if (validCommit && regwrite_r[head_idx_s]) begin
      regCommit = dest_r[head_idx_s];
    end else begin
      regCommit = {(REG+1){1'b0}};
    end
    if (flush) begin
      statusRestore = snap_r[head_idx_s];
    end else begin
      statusRestore = {(WIDTH+1){1'b0}};
    end
  end

  // Pointers and per-entry status bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {(ROB+2){1'b0}};
      tail_r  <= {(ROB+2){1'b0}};
      valid_r <= {DEPTH{1'b0}};
      done_r  <= {DEPTH{1'b0}};
      misp_r  <= {DEPTH{1'b0}};
    end else if (flush) begin
      // Everything younger than the mispredicted branch is squashed.
      head_r  <= head_next_s;
      tail_r  <= head_next_s;
      valid_r <= {DEPTH{1'b0}};
      done_r  <= {DEPTH{1'b0}};
      misp_r  <= {DEPTH{1'b0}};
    end else begin
      if (validCommit) begin
        valid_r[head_idx_s] <= 1'b0;
        head_r              <= head_next_s;
      end
      if (alloc_fire_s) begin
        valid_r[tail_idx_s] <= 1'b1;
        done_r[tail_idx_s]  <= 1'b0;
        misp_r[tail_idx_s]  <= 1'b0;
        tail_r              <= tail_r + PTR_ONE;
      end
      if (cdbValid && valid_r[cdbROB]) begin
        done_r[cdbROB] <= 1'b1;
        misp_r[cdbROB] <= cdbMispredict;
      end
    end
  end

  // Entry payload; only meaningful while the entry is valid, so no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire_s) begin
      regwrite_r[tail_idx_s] <= allocRegWrite;
      dest_r[tail_idx_s]     <= allocDestReg;
      snap_r[tail_idx_s]     <= allocIsBranch ? allocSnap : {(WIDTH+1){1'b0}};
    end else begin
      regwrite_r <= regwrite_r;
    end
  end

endmodule
